key_event_decoder: RTL and testbench



---
 rtl/key_event_decoder.sv | 142 ++++++++++++++
 tb/tb_key_event_decoder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_decoder.sv
// Key event decoder: turns a debounced key level into one-clk short / double / long / repeat pulses.
// Auto-repeat while held after a long press is compiled in only when KEY_REPEAT_EN is defined.

module key_event_decoder #(
  parameter logic             PRESSED_LEVEL = 1'b0,
  parameter int               CNT_W         = 24,
  parameter logic [CNT_W-1:0] LONG_CNT      = CNT_W'(25_000_000),
  parameter logic [CNT_W-1:0] DCLICK_CNT    = CNT_W'(7_500_000),
  parameter logic [CNT_W-1:0] REPEAT_CNT    = CNT_W'(2_500_000)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  input  logic enable,
  output logic short_pulse,
  output logic double_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic pressed,
  output logic busy
);

  typedef enum logic [2:0] {
    ARM    = 3'd0,
    IDLE   = 3'd1,
    PRESS1 = 3'd2,
    WAIT2  = 3'd3,
    PRESS2 = 3'd4,
    LHOLD  = 3'd5
  } state_t;

  typedef struct packed {
    logic short_e;
    logic dbl_e;
    logic long_e;
    logic rpt_e;
  } evt_t;

  localparam logic [CNT_W-1:0] LONG_LIM   = LONG_CNT - CNT_W'(1);
  localparam logic [CNT_W-1:0] DCLICK_LIM = DCLICK_CNT - CNT_W'(1);
`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LIM = REPEAT_CNT - CNT_W'(1);
`else
  logic unused_repeat_cnt;
  assign unused_repeat_cnt = ^REPEAT_CNT;
`endif

  state_t           state, nxt;
  logic [CNT_W-1:0] cnt;
  logic             key_q;
  // key_q's reset value is not a real sample; ARM must not treat it as a release.
  logic             key_vld;
  logic             rel;
  logic             timed;
  logic             rep_clr;
  evt_t             evt;

  assign rel = (key_q != PRESSED_LEVEL);

  always_comb begin
    nxt     = state;
    evt     = '0;
    rep_clr = 1'b0;
    if (!enable) begin
      nxt = ARM;
    end else begin
      case (state)
        ARM:    if (key_vld && rel) nxt = IDLE;
        IDLE:   if (!rel) nxt = PRESS1;
        PRESS1: begin
          if (rel) begin
            nxt = WAIT2;
          end else if (cnt == LONG_LIM) begin
            nxt        = LHOLD;
            evt.long_e = 1'b1;
          end
        end
        WAIT2: begin
          if (!rel) begin
            nxt = PRESS2;
          end else if (cnt == DCLICK_LIM) begin
            nxt         = IDLE;
            evt.short_e = 1'b1;
          end
        end
        PRESS2: begin
          if (rel) begin
            nxt       = IDLE;
            evt.dbl_e = 1'b1;
          end
        end
        LHOLD: begin
          if (rel) begin
            nxt = IDLE;
          end
`ifdef KEY_REPEAT_EN
          else if (cnt == REPEAT_LIM) begin
            evt.rpt_e = 1'b1;
            rep_clr   = 1'b1;
          end
`endif
        end
        default: nxt = ARM;
      endcase
    end
  end

  // States with no timeout keep cnt parked at 0 so it can never wrap while waiting.
  always_comb begin
    timed = (state == PRESS1) || (state == WAIT2);
`ifdef KEY_REPEAT_EN
    if (state == LHOLD) timed = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ARM;
      cnt          <= '0;
      key_q        <= ~PRESSED_LEVEL;
      key_vld      <= 1'b0;
      short_pulse  <= 1'b0;
      double_pulse <= 1'b0;
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
      pressed      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      key_q        <= key_in;
      key_vld      <= 1'b1;
      pressed      <= (key_in == PRESSED_LEVEL);
      state        <= nxt;
      cnt          <= ((nxt != state) || rep_clr || !timed) ? '0 : cnt + CNT_W'(1);
      short_pulse  <= evt.short_e;
      double_pulse <= evt.dbl_e;
      long_pulse   <= evt.long_e;
      repeat_pulse <= evt.rpt_e;
      busy         <= (nxt != IDLE) && (nxt != ARM);
    end
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder with short timing parameters (LONG=20, DCLICK=10, REPEAT=5).
// Inputs change 1 ns after a rising edge; hold index i in the monitor is edge Ei of that level.

module tb_key_event_decoder;

  logic clk = 1'b0;
  logic rst_n, key_in, enable;
  logic short_pulse, double_pulse, long_pulse, repeat_pulse, pressed, busy;

  int errors = 0;
  int checks = 0;
  int n_short, n_double, n_long, n_rep, n_busy, n_multi;
  int short_at, double_at, long_at;
  int rep_at[$];

  always #5 clk = ~clk;

  key_event_decoder #(
    .PRESSED_LEVEL(1'b0),
    .CNT_W        (24),
    .LONG_CNT     (24'd20),
    .DCLICK_CNT   (24'd10),
    .REPEAT_CNT   (24'd5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_in      (key_in),
    .enable      (enable),
    .short_pulse (short_pulse),
    .double_pulse(double_pulse),
    .long_pulse  (long_pulse),
    .repeat_pulse(repeat_pulse),
    .pressed     (pressed),
    .busy        (busy)
  );

  task automatic clr_mon();
    n_short = 0; n_double = 0; n_long = 0; n_rep = 0; n_busy = 0; n_multi = 0;
    short_at = -1; double_at = -1; long_at = -1;
    rep_at.delete();
  endtask

  // Drive a key level for n edges and record which pulses appear on which edge.
  task automatic hold(input logic lvl, input int n);
    key_in = lvl;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (short_pulse)  begin n_short++;  short_at  = i; end
      if (double_pulse) begin n_double++; double_at = i; end
      if (long_pulse)   begin n_long++;   long_at   = i; end
      if (repeat_pulse) begin n_rep++;    rep_at.push_back(i); end
      if (busy) n_busy++;
      if (int'(short_pulse) + int'(double_pulse) + int'(long_pulse) + int'(repeat_pulse) > 1)
        n_multi++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; key_in = 1'b1; enable = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if ({short_pulse, double_pulse, long_pulse, repeat_pulse, pressed, busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 000000",
               {short_pulse, double_pulse, long_pulse, repeat_pulse, pressed, busy});
    end
    key_in = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (pressed !== 1'b0) begin
      errors++; $display("FAIL reset_pressed_held: got %b want 0", pressed);
    end
    rst_n = 1'b1;
    clr_mon();
    hold(1'b0, 40);
    checks++;
    if (n_short + n_double + n_long + n_rep != 0) begin
      errors++; $display("FAIL arm_held_pulses: got %0d pulses want 0", n_short + n_double + n_long + n_rep);
    end
    checks++;
    if (n_busy != 0) begin
      errors++; $display("FAIL arm_held_busy: got %0d busy clks want 0", n_busy);
    end
    checks++;
    if (pressed !== 1'b1) begin
      errors++; $display("FAIL arm_pressed: got %b want 1", pressed);
    end
  endtask

  task automatic test_arm_short();
    clr_mon();
    hold(1'b1, 3);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL arm_to_idle_busy: got %b want 0", busy);
    end
    hold(1'b0, 5);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL press1_busy: got %b want 1", busy);
    end
    clr_mon();
    hold(1'b1, 20);
    checks++;
    if (n_short != 1 || short_at != 11) begin
      errors++; $display("FAIL short_pulse: got count %0d at E%0d want 1 at E11", n_short, short_at);
    end
    checks++;
    if (n_double + n_long + n_rep != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL short_others: got %0d other pulses busy %b want 0 busy 0",
                         n_double + n_long + n_rep, busy);
    end
  endtask

  task automatic test_double();
    clr_mon();
    hold(1'b0, 5);
    hold(1'b1, 4);
    hold(1'b0, 5);
    hold(1'b1, 20);
    checks++;
    if (n_double != 1 || double_at != 1) begin
      errors++; $display("FAIL double_pulse: got count %0d at E%0d want 1 at E1", n_double, double_at);
    end
    checks++;
    if (n_short != 0 || n_long != 0) begin
      errors++; $display("FAIL double_no_short: got short %0d long %0d want 0 0", n_short, n_long);
    end
  endtask

  task automatic test_long();
    clr_mon();
    hold(1'b0, 45);
    checks++;
    if (n_long != 1 || long_at != 21) begin
      errors++; $display("FAIL long_pulse: got count %0d at E%0d want 1 at E21", n_long, long_at);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL lhold_busy: got %b want 1", busy);
    end
`ifdef KEY_REPEAT_EN
    checks++;
    if (rep_at.size() != 4 || rep_at[0] != 26 || rep_at[1] != 31 || rep_at[2] != 36 || rep_at[3] != 41) begin
      errors++; $display("FAIL repeat_ticks: got %0d ticks first E%0d want 4 at E26/31/36/41",
                         n_rep, (rep_at.size() > 0) ? rep_at[0] : -1);
    end
`else
    checks++;
    if (n_rep != 0) begin
      errors++; $display("FAIL repeat_disabled: got %0d ticks want 0", n_rep);
    end
`endif
    checks++;
    if (n_multi != 0 || n_short != 0) begin
      errors++; $display("FAIL long_exclusive: got multi %0d short %0d want 0 0", n_multi, n_short);
    end
    clr_mon();
    hold(1'b1, 15);
    checks++;
    if (n_short + n_double + n_long + n_rep != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL lhold_release: got %0d pulses busy %b want 0 busy 0",
                         n_short + n_double + n_long + n_rep, busy);
    end
  endtask

  task automatic test_long_boundary();
    clr_mon();
    hold(1'b0, 20);
    hold(1'b1, 15);
    checks++;
    if (n_long != 0 || n_short != 1 || short_at != 11) begin
      errors++; $display("FAIL release_beats_long: got long %0d short %0d at E%0d want 0, 1 at E11",
                         n_long, n_short, short_at);
    end
    clr_mon();
    hold(1'b0, 21);
    hold(1'b1, 15);
    checks++;
    if (n_long != 1 || n_short != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL long_one_clk_later: got long %0d short %0d busy %b want 1 0 0",
                         n_long, n_short, busy);
    end
  endtask

  task automatic test_dclick_boundary();
    clr_mon();
    hold(1'b0, 5);
    hold(1'b1, 10);
    hold(1'b0, 3);
    hold(1'b1, 5);
    checks++;
    if (n_short != 0 || n_double != 1 || double_at != 1) begin
      errors++; $display("FAIL press_beats_timeout: got short %0d double %0d at E%0d want 0, 1 at E1",
                         n_short, n_double, double_at);
    end
  endtask

  task automatic test_enable();
    clr_mon();
    hold(1'b0, 5);
    hold(1'b1, 4);
    enable = 1'b0;
    @(posedge clk); #1;
    enable = 1'b1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL disable_busy: got %b want 0", busy);
    end
    clr_mon();
    hold(1'b1, 20);
    checks++;
    if (n_short + n_double + n_long + n_rep != 0) begin
      errors++; $display("FAIL disable_no_short: got %0d pulses want 0", n_short + n_double + n_long + n_rep);
    end
    clr_mon();
    hold(1'b0, 3);
    hold(1'b1, 15);
    checks++;
    if (n_short != 1 || short_at != 11) begin
      errors++; $display("FAIL reenable_short: got count %0d at E%0d want 1 at E11", n_short, short_at);
    end
    enable = 1'b0;
    clr_mon();
    hold(1'b0, 5);
    enable = 1'b1;
    hold(1'b0, 30);
    checks++;
    if (n_short + n_double + n_long + n_rep != 0 || n_busy != 0) begin
      errors++; $display("FAIL reenable_held: got %0d pulses %0d busy clks want 0 0",
                         n_short + n_double + n_long + n_rep, n_busy);
    end
    clr_mon();
    hold(1'b1, 15);
    checks++;
    if (n_short + n_double + n_long + n_rep != 0) begin
      errors++; $display("FAIL reenable_release: got %0d pulses want 0", n_short + n_double + n_long + n_rep);
    end
  endtask

  task automatic test_reset_mid();
    clr_mon();
    hold(1'b0, 25);
    checks++;
    if (n_long != 1 || busy !== 1'b1) begin
      errors++; $display("FAIL pre_reset_lhold: got long %0d busy %b want 1 1", n_long, busy);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({short_pulse, double_pulse, long_pulse, repeat_pulse, pressed, busy} !== 6'b0) begin
      errors++; $display("FAIL async_reset: got %b want 000000",
                         {short_pulse, double_pulse, long_pulse, repeat_pulse, pressed, busy});
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    clr_mon();
    hold(1'b0, 30);
    checks++;
    if (n_short + n_double + n_long + n_rep != 0 || n_busy != 0) begin
      errors++; $display("FAIL post_reset_arm: got %0d pulses %0d busy clks want 0 0",
                         n_short + n_double + n_long + n_rep, n_busy);
    end
    clr_mon();
    hold(1'b1, 3);
    hold(1'b0, 3);
    hold(1'b1, 15);
    checks++;
    if (n_short != 1 || short_at != 11) begin
      errors++; $display("FAIL post_reset_short: got count %0d at E%0d want 1 at E11", n_short, short_at);
    end
  endtask

  initial begin
    rst_n = 1'b0; key_in = 1'b1; enable = 1'b1;
    clr_mon();
    #1;
    test_reset();
    test_arm_short();
    test_double();
    test_long();
    test_long_boundary();
    test_dclick_boundary();
    test_enable();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
